// File: rtl/keccak_collect_if.sv
// Word-in / block-out handshake bundle for keccak_collect.
// in_last exists only when KECCAK_COLLECT_LAST_EN is defined.
interface keccak_collect_if #(
    parameter int W     = 32,
    parameter int WORDS = 16
);
    localparam int CW = $clog2(WORDS + 1);

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in32;
`ifdef KECCAK_COLLECT_LAST_EN
    logic               in_last;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [W*WORDS-1:0] out512;
    logic [CW-1:0]      count;

    modport master (
        output in_valid,
        output in32,
`ifdef KECCAK_COLLECT_LAST_EN
        output in_last,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out512,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in32,
`ifdef KECCAK_COLLECT_LAST_EN
        input  in_last,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out512,
        output count
    );
endinterface

// File: rtl/keccak_collect.sv
// Packs 32-bit words into a 512-bit Keccak block, first word in the top slot.
// Optional early block end via in_last: define KECCAK_COLLECT_LAST_EN.
module keccak_collect #(
    parameter int W     = 32,
    parameter int WORDS = 16
) (
    input  logic            clk,
    input  logic            reset,
    keccak_collect_if.slave bus
);
    localparam int CW = $clog2(WORDS + 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W*WORDS-1:0] data_q, data_d;
    logic               last_w;

`ifdef KECCAK_COLLECT_LAST_EN
    assign last_w = bus.in_last;
`else
    assign last_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    // Word k goes to slot WORDS-1-k, so the first word is MSB.
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            data_d[W*(WORDS-1-k) +: W] = bus.in32;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WORDS - 1) || last_w) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
        endcase
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == FULL);
    assign bus.out512    = data_q;
    assign bus.count     = cnt_q;
endmodule

// File: tb/tb_keccak_collect.sv
// Directed test of keccak_collect: reset, full/gapped/back-to-back blocks,
// output backpressure and, when enabled, early end via in_last.
module tb_keccak_collect;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    keccak_collect_if #(.W(32), .WORDS(16)) bus ();

    keccak_collect dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] PAT =
        256'h00001111_22223333_44445555_66667777_88889999_AAAABBBB_CCCCDDDD_EEEEFFFF;
    localparam logic [511:0] BLK = {PAT, PAT};

    logic [31:0] wv [8] = '{32'h00001111, 32'h22223333, 32'h44445555,
                            32'h66667777, 32'h88889999, 32'hAAAABBBB,
                            32'hCCCCDDDD, 32'hEEEEFFFF};

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in32     = w;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in32      = '0;
        bus.out_ready = 1'b0;
`ifdef KECCAK_COLLECT_LAST_EN
        bus.in_last   = 1'b0;
`endif
        #12;
        reset = 1'b1;
        cyc();
        chk("rst_in_ready", 512'(bus.in_ready), 512'd1);
        chk("rst_out_valid", 512'(bus.out_valid), 512'd0);
        chk("rst_count", 512'(bus.count), 512'd0);
        chk("rst_out512", bus.out512, 512'd0);

        // Test 1: reset mid-fill
        for (int i = 0; i < 5; i++) send(wv[i]);
        chk("mid_count", 512'(bus.count), 512'd5);
        chk("mid_data", bus.out512, {PAT[255:96], 352'd0});
        #2 reset = 1'b0;
        #1;
        chk("async_count", 512'(bus.count), 512'd0);
        chk("async_out512", bus.out512, 512'd0);
        chk("async_out_valid", 512'(bus.out_valid), 512'd0);
        #2 reset = 1'b1;
        cyc();
        chk("rel_in_ready", 512'(bus.in_ready), 512'd1);
        chk("rel_count", 512'(bus.count), 512'd0);

        // Test 2: 16 back-to-back words
        for (int i = 0; i < 15; i++) send(wv[i % 8]);
        chk("t2_15_valid", 512'(bus.out_valid), 512'd0);
        chk("t2_15_count", 512'(bus.count), 512'd15);
        send(wv[7]);
        chk("t2_out_valid", 512'(bus.out_valid), 512'd1);
        chk("t2_in_ready", 512'(bus.in_ready), 512'd0);
        chk("t2_count", 512'(bus.count), 512'd16);
        chk("t2_block", bus.out512, BLK);

        // Test 3: backpressure with pending input
        bus.in_valid = 1'b1;
        bus.in32     = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t3_in_ready", 512'(bus.in_ready), 512'd0);
            chk("t3_block", bus.out512, BLK);
        end
        chk("t3_count", 512'(bus.count), 512'd16);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t3_clr_count", 512'(bus.count), 512'd0);
        chk("t3_clr_out512", bus.out512, 512'd0);
        chk("t3_clr_in_ready", 512'(bus.in_ready), 512'd1);
        chk("t3_clr_valid", 512'(bus.out_valid), 512'd0);

        // Test 4: gapped input
        begin
            int acc;
            acc = 0;
            for (int i = 0; i < 32; i++) begin
                bus.in_valid = (i % 2 == 0);
                bus.in32     = (i % 2 == 0) ? wv[(i / 2) % 8] : 32'h12345678;
                cyc();
                if (i % 2 == 0) acc++;
                chk("t4_count", 512'(bus.count), 512'(acc));
            end
            bus.in_valid = 1'b0;
        end
        chk("t4_valid", 512'(bus.out_valid), 512'd1);
        chk("t4_block", bus.out512, BLK);

        // Test 5: second block right after the output handshake
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in32      = 32'hFFFFFFFF;
        cyc();
        chk("t5_handoff_count", 512'(bus.count), 512'd0);
        chk("t5_handoff_data", bus.out512, 512'd0);
        for (int i = 0; i < 15; i++) cyc();
        chk("t5_15_count", 512'(bus.count), 512'd15);
        chk("t5_15_data", bus.out512, {{15{32'hFFFFFFFF}}, 32'd0});
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("t5_valid", 512'(bus.out_valid), 512'd1);
        chk("t5_count", 512'(bus.count), 512'd16);
        chk("t5_block", bus.out512, {512{1'b1}});
        drain();
        chk("t5_drained", 512'(bus.count), 512'd0);

`ifdef KECCAK_COLLECT_LAST_EN
        // Test 6: early end on in_last
        send(32'hA);
        bus.in_last = 1'b1;
        chk("t6_idle_last", 512'(bus.count), 512'd1);
        cyc();
        chk("t6_last_no_valid", 512'(bus.out_valid), 512'd0);
        send(32'hB);
        bus.in_last = 1'b0;
        chk("t6_b_last_count", 512'(bus.count), 512'd2);
        chk("t6_b_last_valid", 512'(bus.out_valid), 512'd1);
        drain();
        send(32'hA);
        send(32'hB);
        bus.in_last = 1'b1;
        send(32'hC);
        bus.in_last = 1'b0;
        chk("t6_valid", 512'(bus.out_valid), 512'd1);
        chk("t6_count", 512'(bus.count), 512'd3);
        chk("t6_block", bus.out512,
            {32'h0000000A, 32'h0000000B, 32'h0000000C, 416'd0});
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
